// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch stage feeding decode through a 2-entry buffer.
// Define FETCH_PERF_CNT_EN to add the F_stall_cycles decode-stall counter.
module fetch_unit #(
   parameter int                      ADDRESS_SIZE = 32,
   parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    F_req,
   output logic [ADDRESS_SIZE-1:0] F_req_addr,
   input  logic                    F_resp_valid,
   input  logic [ADDRESS_SIZE-1:0] F_resp_data,
   input  logic                    D_b,
   input  logic [ADDRESS_SIZE-1:0] D_bImmediate,
   input  logic                    D_stall,
   output logic                    F_valid,
   output logic [ADDRESS_SIZE-1:0] F_instruction,
   output logic [ADDRESS_SIZE-1:0] F_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]             F_stall_cycles
`endif
);
   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;
   state_t                  r_state, w_state_nxt;
   logic [ADDRESS_SIZE-1:0] r_pc, w_pc_nxt;
   logic [1:0]              r_count, w_count_nxt;
   logic [ADDRESS_SIZE-1:0] r_fifo_pc [2];
   logic [ADDRESS_SIZE-1:0] r_fifo_ins [2];
   logic                    w_pop, w_push, w_widx, w_unused;
   logic [1:0]              w_widx_full;
   assign w_unused      = &{1'b0, D_bImmediate[1:0]};
   assign F_req         = r_state == S_FETCH;
   assign F_req_addr    = r_pc;
   assign F_valid       = r_count != 2'd0;
   assign F_pc          = r_fifo_pc[0];
   assign F_instruction = r_fifo_ins[0];
   assign w_pop         = F_valid && !D_stall;
   assign w_push        = r_state == S_FETCH && F_resp_valid && !D_b;
   // a simultaneous pop shifts the tail down, so the push lands one slot lower
   assign w_widx_full   = r_count - {1'b0, w_pop};
   assign w_widx        = w_widx_full[0];
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (D_b) begin
         w_count_nxt = 2'd0;
         w_pc_nxt    = {D_bImmediate[ADDRESS_SIZE-1:2], 2'b00};
         w_state_nxt = (r_state == S_HOLD || F_resp_valid) ? S_FETCH : S_DISCARD;
      end else begin
         case (r_state)
            S_FETCH: if (F_resp_valid) begin
               w_pc_nxt    = r_pc + ADDRESS_SIZE'(4);
               w_state_nxt = (w_count_nxt == 2'd2) ? S_HOLD : S_FETCH;
            end
            S_HOLD:    w_state_nxt = w_pop ? S_FETCH : S_HOLD;
            S_DISCARD: w_state_nxt = F_resp_valid ? S_FETCH : S_DISCARD;
            default:   w_state_nxt = S_FETCH;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_PC;
         r_count <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_count <= w_count_nxt;
      end
   end
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_fifo_pc[0]  <= r_fifo_pc[1];
         r_fifo_ins[0] <= r_fifo_ins[1];
      end
      if (w_push) begin
         r_fifo_pc[w_widx]  <= r_pc;
         r_fifo_ins[w_widx] <= F_resp_data;
      end
   end
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cycles;
   assign F_stall_cycles = r_stall_cycles;
   always_ff @(posedge clk) begin
      if (reset)
         r_stall_cycles <= '0;
      else if (F_valid && D_stall && r_stall_cycles != '1)
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus a same-cycle-memory throughput sequence for fetch_unit.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset, F_req, F_resp_valid, D_b, D_stall, F_valid;
   logic [31:0] F_req_addr, F_resp_data, D_bImmediate, F_instruction, F_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] F_stall_cycles;
`endif
   int n_vec = 0;
   int n_err = 0;

   fetch_unit dut (
      .clk(clk), .reset(reset), .F_req(F_req), .F_req_addr(F_req_addr),
      .F_resp_valid(F_resp_valid), .F_resp_data(F_resp_data), .D_b(D_b),
      .D_bImmediate(D_bImmediate), .D_stall(D_stall), .F_valid(F_valid),
      .F_instruction(F_instruction), .F_pc(F_pc)
`ifdef FETCH_PERF_CNT_EN
      , .F_stall_cycles(F_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic        rst, rv;
      logic [31:0] rdata;
      logic        b;
      logic [31:0] bimm;
      logic        stall;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc, e_ins;
      logic        chk_perf;
      logic [31:0] e_perf;
   } vec_t;

   vec_t vt [26];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s v%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic vec(input int i, input logic c, input logic rs, input logic rv, input logic [31:0] rd,
                      input logic b, input logic [31:0] bi, input logic st, input logic er,
                      input logic [31:0] ea, input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                      input logic cp, input logic [31:0] epf);
      vt[i] = '{c, rs, rv, rd, b, bi, st, er, ea, ev, ep, ei, cp, epf};
   endtask

   initial begin
      //       i  chk rst rv data          b  bimm          st req addr          vld pc            instr        cp pf
      vec( 0, 0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0,         0, 0);
      vec( 1, 1, 0, 1, 32'h1111_0000, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0,         32'h0,         1, 0);
      vec( 2, 1, 0, 1, 32'h2222_0004, 0, 32'h0,         0, 1, 32'h4,         1, 32'h0,         32'h1111_0000, 0, 0);
      vec( 3, 1, 0, 1, 32'h3333_0008, 0, 32'h0,         0, 1, 32'h8,         1, 32'h4,         32'h2222_0004, 0, 0);
      vec( 4, 1, 0, 1, 32'h4444_000C, 0, 32'h0,         1, 1, 32'hC,         1, 32'h8,         32'h3333_0008, 0, 0);
      vec( 5, 1, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h10,        1, 32'h8,         32'h3333_0008, 1, 1);
      vec( 6, 1, 0, 1, 32'hBAD0_BAD0, 0, 32'h0,         1, 0, 32'h10,        1, 32'h8,         32'h3333_0008, 0, 0);
      vec( 7, 1, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h10,        1, 32'h8,         32'h3333_0008, 0, 0);
      vec( 8, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h10,        1, 32'h8,         32'h3333_0008, 1, 4);
      vec( 9, 1, 0, 1, 32'h5555_0010, 0, 32'h0,         0, 1, 32'h10,        1, 32'hC,         32'h4444_000C, 0, 0);
      vec(10, 1, 0, 1, 32'h6666_0014, 0, 32'h0,         1, 1, 32'h14,        1, 32'h10,        32'h5555_0010, 0, 0);
      vec(11, 1, 0, 0, 32'h0,         1, 32'h0000_0103, 1, 0, 32'h18,        1, 32'h10,        32'h5555_0010, 0, 0);
      vec(12, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h100,       0, 32'h0,         32'h0,         1, 6);
      vec(13, 1, 0, 0, 32'h0,         1, 32'h0000_0200, 0, 1, 32'h100,       0, 32'h0,         32'h0,         0, 0);
      vec(14, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h200,       0, 32'h0,         32'h0,         0, 0);
      vec(15, 1, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0, 0, 32'h200,       0, 32'h0,         32'h0,         0, 0);
      vec(16, 1, 0, 1, 32'h7777_0200, 0, 32'h0,         0, 1, 32'h200,       0, 32'h0,         32'h0,         0, 0);
      vec(17, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h204,       1, 32'h200,       32'h7777_0200, 0, 0);
      vec(18, 1, 0, 1, 32'hDEAD_0001, 1, 32'hFFFF_FFFE, 0, 1, 32'h204,       0, 32'h0,         32'h0,         0, 0);
      vec(19, 1, 0, 1, 32'h8888_FFFC, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0, 0);
      vec(20, 1, 0, 1, 32'h9999_0000, 0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'h8888_FFFC, 0, 0);
      vec(21, 1, 1, 0, 32'h0,         0, 32'h0,         1, 0, 32'h4,         1, 32'hFFFF_FFFC, 32'h8888_FFFC, 1, 7);
      vec(22, 1, 0, 0, 32'h0,         1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         32'h0,         1, 0);
      vec(23, 1, 0, 1, 32'hDEAD_0002, 1, 32'h0000_0080, 0, 0, 32'h40,        0, 32'h0,         32'h0,         0, 0);
      vec(24, 1, 0, 1, 32'hAAAA_0080, 0, 32'h0,         0, 1, 32'h80,        0, 32'h0,         32'h0,         0, 0);
      vec(25, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h84,        1, 32'h80,        32'hAAAA_0080, 0, 0);

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         reset = vt[i].rst; F_resp_valid = vt[i].rv; F_resp_data = vt[i].rdata;
         D_b = vt[i].b; D_bImmediate = vt[i].bimm; D_stall = vt[i].stall;
         if (vt[i].chk) begin
            chk("F_req", i, {31'b0, F_req}, {31'b0, vt[i].e_req});
            chk("F_valid", i, {31'b0, F_valid}, {31'b0, vt[i].e_valid});
            if (vt[i].e_req) chk("F_req_addr", i, F_req_addr, vt[i].e_addr);
            if (vt[i].e_valid) begin
               chk("F_pc", i, F_pc, vt[i].e_pc);
               chk("F_instruction", i, F_instruction, vt[i].e_ins);
            end
`ifdef FETCH_PERF_CNT_EN
            if (vt[i].chk_perf) chk("F_stall_cycles", i, F_stall_cycles, vt[i].e_perf);
`endif
         end
      end

      // same-cycle memory: reset, then expect PCs 0,4,8,C with instr = ~pc
      @(negedge clk);
      reset = 1'b1; F_resp_valid = 1'b0; D_b = 1'b0; D_stall = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         F_resp_valid = F_req;
         F_resp_data  = ~F_req_addr;
         if (c >= 1 && c <= 4) begin
            chk("tput_valid", 100 + c, {31'b0, F_valid}, 32'd1);
            chk("tput_pc", 100 + c, F_pc, 32'(4 * (c - 1)));
            chk("tput_instr", 100 + c, F_instruction, ~32'(4 * (c - 1)));
         end
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
